uart_cmd_ctrl: RTL

Sequencing and configuration controller for the configurable-baud UART receiver. Drains received bytes via the receiver's rdy/clr_rdy handshake and assembles 3-byte command frames (opcode, data high, data low) with an inter-byte timeout. Handles the baud-reconfiguration opcode internally by driving the receiver's baud_cnt; all other commands go to the command consumer over a rdy/clr handshake.

---
 rtl/uart_cmd_pkg.sv | 14 +
 rtl/uart_cmd_timer.sv | 27 ++
 rtl/uart_cmd_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
package uart_cmd_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HI       = 2'd1,
    LO       = 2'd2,
    DISPATCH = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_DEFAULT        = 16'd434;
  localparam logic [15:0] BAUD_MIN            = 16'd16;
  localparam logic [7:0]  BAUD_OP             = 8'hB0;
  localparam logic [19:0] TIMEOUT_CYC_DEFAULT = 20'd500000;
endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte idle timer: 20-bit up-counter, expired at LIMIT-1.
module uart_cmd_timer #(
  parameter logic [19:0] LIMIT = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [19:0] count_q;

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 20'd0;
    end else if (clr_i) begin
      count_q <= 20'd0;
    end else if (en_i) begin
      count_q <= count_q + 20'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign expired_o = (count_q == (LIMIT - 20'd1));
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 3-byte command frames from the UART receiver; handles baud
// updates internally and hands other commands to the consumer.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic [15:0] baud_cnt,
  output logic [7:0]  cmd,
  output logic [15:0] cmd_data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        timeout_err,
  output logic        baud_err,
  output logic        ovr_err
);
  state_t      state_q, state_d;
  logic        clr_rdy_q, clr_rdy_d;
  logic [7:0]  op_q, op_d, hi_q, hi_d, lo_q, lo_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        tmo_err_q, tmo_err_d, baud_err_q, baud_err_d, ovr_err_q, ovr_err_d;
  logic        rdy_s, capture_s, timeout_s, expired_s, tmr_clr_s, tmr_en_s;
  logic [15:0] frame_s;

  // rx_rdy is still high on the edge that sees our own clr_rdy; ignore it then
  assign rdy_s     = rx_rdy & ~clr_rdy_q;
  assign frame_s   = {hi_q, lo_q};
  assign tmr_en_s  = (state_q == HI) || (state_q == LO);
  assign tmr_clr_s = capture_s | timeout_s | ~tmr_en_s;

  uart_cmd_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr_s),
    .en_i      (tmr_en_s),
    .expired_o (expired_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; a waiting byte beats an expiring timer
  always_comb begin
    state_d   = state_q;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_s) begin
          capture_s = 1'b1;
          state_d   = HI;
        end else begin
          state_d = IDLE;
        end
      end
      HI, LO: begin
        if (rdy_s) begin
          capture_s = 1'b1;
          state_d   = (state_q == HI) ? LO : DISPATCH;
        end else if (expired_s) begin
          timeout_s = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      DISPATCH: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    clr_rdy_d  = capture_s;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    baud_d     = baud_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    cmd_rdy_d  = cmd_rdy_q;
    tmo_err_d  = timeout_s;
    baud_err_d = 1'b0;
    ovr_err_d  = 1'b0;
    if (capture_s) begin
      case (state_q)
        IDLE:    op_d = rx_data;
        HI:      hi_d = rx_data;
        LO:      lo_d = rx_data;
        default: op_d = op_q;
      endcase
    end else begin
      op_d = op_q;
    end
    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
    if (state_q == DISPATCH) begin
      if (op_q == BAUD_OP) begin
        if (frame_s >= BAUD_MIN) begin
          baud_d = frame_s;
        end else begin
          baud_err_d = 1'b1;
        end
      end else begin
        cmd_d     = op_q;
        data_d    = frame_s;
        cmd_rdy_d = 1'b1;
        ovr_err_d = cmd_rdy_q & ~clr_cmd_rdy;
      end
    end else begin
      baud_d = baud_q;
    end
  end

  // output and frame-slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_rdy_q  <= 1'b0;
      op_q       <= 8'h00;
      hi_q       <= 8'h00;
      lo_q       <= 8'h00;
      baud_q     <= BAUD_DEFAULT;
      cmd_q      <= 8'h00;
      data_q     <= 16'h0000;
      cmd_rdy_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      baud_err_q <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      clr_rdy_q  <= clr_rdy_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      baud_q     <= baud_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      cmd_rdy_q  <= cmd_rdy_d;
      tmo_err_q  <= tmo_err_d;
      baud_err_q <= baud_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign clr_rdy     = clr_rdy_q;
  assign baud_cnt    = baud_q;
  assign cmd         = cmd_q;
  assign cmd_data    = data_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign timeout_err = tmo_err_q;
  assign baud_err    = baud_err_q;
  assign ovr_err     = ovr_err_q;
endmodule
